// File: rtl/cmplx_mult_16b_pipe_pkg.sv
// Shared widths, types and add/sub helper for the pipelined complex multiplier.
// Holds the FFT datapath widths: 16b data, 32b products, 6b sample index.
package cmplx_mult_16b_pipe_pkg;

  localparam int FFT_DW    = 16;
  localparam int FFT_PW    = 32;
  localparam int FFT_IDX_W = 6;

  typedef logic signed [FFT_DW-1:0] data_t;
  typedef logic signed [FFT_PW-1:0] prod_t;

  // Wraps modulo 2^32; the downstream adjusters never need saturation.
  function automatic prod_t combine(input prod_t i_x, input prod_t i_y, input logic i_sub);
    return i_sub ? prod_t'(i_x - i_y) : prod_t'(i_x + i_y);
  endfunction

endpackage

// File: rtl/cmplx_mult_16b_pipe_mult.sv
// mult_16x16_s: registered signed 16x16->32 multiplier with clock enable.
// Used four times in the middle stage of cmplx_mult_16b_pipe.
module mult_16x16_s
  import cmplx_mult_16b_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  data_t i_a,
  input  data_t i_b,
  output prod_t o_p
);

  prod_t r_p;
  prod_t w_a;
  prod_t w_b;

  assign w_a = prod_t'(i_a);
  assign w_b = prod_t'(i_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= prod_t'(w_a * w_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/cmplx_mult_16b_pipe.sv
// 3-stage pipelined signed complex multiplier P = A*B with valid/ready and index sideband.
// Define CMULT_CONJ_EN to add conj_b, which selects A*conj(B) per sample.
module cmplx_mult_16b_pipe
  import cmplx_mult_16b_pipe_pkg::*;
#(
  parameter int IDX_W = FFT_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CMULT_CONJ_EN
  input  logic             conj_b,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  data_t            A_re,
  input  data_t            A_im,
  input  data_t            B_re,
  input  data_t            B_im,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output prod_t            P_re,
  output prod_t            P_im,
  output logic [IDX_W-1:0] out_idx
);

  // A single advance for all stages: bubbles are held, not squeezed, during a stall.
  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  data_t            r_a_re, r_a_im, r_b_re, r_b_im;
  logic [IDX_W-1:0] r_idx1, r_idx2, r_idx3;
  logic             r_v1, r_v2, r_v3;
  prod_t            r_p_re, r_p_im;
  logic             w_conj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_re <= '0;
      r_a_im <= '0;
      r_b_re <= '0;
      r_b_im <= '0;
      r_idx1 <= '0;
      r_v1   <= 1'b0;
    end else if (w_adv) begin
      r_a_re <= A_re;
      r_a_im <= A_im;
      r_b_re <= B_re;
      r_b_im <= B_im;
      r_idx1 <= in_idx;
      r_v1   <= in_valid;
    end
  end

`ifdef CMULT_CONJ_EN
  logic r_conj1, r_conj2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conj1 <= 1'b0;
      r_conj2 <= 1'b0;
    end else if (w_adv) begin
      r_conj1 <= conj_b;
      r_conj2 <= r_conj1;
    end
  end

  assign w_conj = r_conj2;
`else
  assign w_conj = 1'b0;
`endif

  prod_t w_rr, w_ii, w_ri, w_ir;

  mult_16x16_s u_mult_rr (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_a(r_a_re), .i_b(r_b_re), .o_p(w_rr));
  mult_16x16_s u_mult_ii (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_a(r_a_im), .i_b(r_b_im), .o_p(w_ii));
  mult_16x16_s u_mult_ri (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_a(r_a_re), .i_b(r_b_im), .o_p(w_ri));
  mult_16x16_s u_mult_ir (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_a(r_a_im), .i_b(r_b_re), .o_p(w_ir));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx2 <= '0;
      r_v2   <= 1'b0;
    end else if (w_adv) begin
      r_idx2 <= r_idx1;
      r_v2   <= r_v1;
    end
  end

  // Conjugate: re = rr + ii, im = ir - ri; normal: re = rr - ii, im = ri + ir.
  prod_t w_p_re, w_p_im;
  assign w_p_re = combine(w_rr, w_ii, ~w_conj);
  assign w_p_im = w_conj ? combine(w_ir, w_ri, 1'b1) : combine(w_ri, w_ir, 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_re <= '0;
      r_p_im <= '0;
      r_idx3 <= '0;
      r_v3   <= 1'b0;
    end else if (w_adv) begin
      r_p_re <= w_p_re;
      r_p_im <= w_p_im;
      r_idx3 <= r_idx2;
      r_v3   <= r_v2;
    end
  end

  assign out_valid = r_v3;
  assign P_re      = r_p_re;
  assign P_im      = r_p_im;
  assign out_idx   = r_idx3;

endmodule

// File: tb/tb_cmplx_mult_16b_pipe.sv
// Self-checking bench for cmplx_mult_16b_pipe: directed vectors, streaming with
// random backpressure, bubbles and mid-stream reset against a queue-based model.
module tb_cmplx_mult_16b_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               conj_b;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] A_re, A_im, B_re, B_im;
  logic [5:0]         in_idx;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] P_re, P_im;
  logic [5:0]         out_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [5:0]  idx;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cmplx_mult_16b_pipe #(.IDX_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CMULT_CONJ_EN
    .conj_b   (conj_b),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A_re     (A_re),
    .A_im     (A_im),
    .B_re     (B_re),
    .B_im     (B_im),
    .in_idx   (in_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P_re     (P_re),
    .P_im     (P_im),
    .out_idx  (out_idx)
  );

  // Full-precision complex product in 64-bit integers, then reduced mod 2^32.
  function automatic exp_t model(input logic signed [15:0] ar, input logic signed [15:0] ai,
                                 input logic signed [15:0] br, input logic signed [15:0] bi,
                                 input logic [5:0] idx, input logic cj);
    longint re, im;
    exp_t e;
    if (cj) begin
      re = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
      im = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
    end else begin
      re = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
      im = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
    end
    e.re  = re[31:0];
    e.im  = im[31:0];
    e.idx = idx;
    return e;
  endfunction

  task automatic randomize_inputs(input int idx);
    A_re   = 16'($urandom);
    A_im   = 16'($urandom);
    B_re   = 16'($urandom);
    B_im   = 16'($urandom);
    in_idx = 6'(idx);
`ifdef CMULT_CONJ_EN
    conj_b = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; conj_b = 1'b0;
    A_re = '0; A_im = '0; B_re = '0; B_im = '0; in_idx = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (P_re !== 32'h0 || P_im !== 32'h0) begin errors++; $display("FAIL reset_P: got %h/%h expected 0/0", P_re, P_im); end
    checks++; if (out_idx !== 6'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input logic signed [15:0] ar, input logic signed [15:0] ai,
                             input logic signed [15:0] br, input logic signed [15:0] bi, input logic [5:0] idx,
                             input logic cj, input logic [31:0] exp_re, input logic [31:0] exp_im);
    @(posedge clk); #1;
    A_re = ar; A_im = ai; B_re = br; B_im = bi; in_idx = idx; conj_b = cj;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat1: out_valid got %b expected 0", name, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat2: out_valid got %b expected 0", name, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_lat3: out_valid got %b expected 1", name, out_valid); end
    checks++; if (P_re !== exp_re) begin errors++; $display("FAIL %s_re: got %h expected %h", name, P_re, exp_re); end
    checks++; if (P_im !== exp_im) begin errors++; $display("FAIL %s_im: got %h expected %h", name, P_im, exp_im); end
    checks++; if (out_idx !== idx) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", name, out_idx, idx); end
    @(posedge clk); #1;
    conj_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic stall_prev = 1'b0;
    logic acc_in;
    logic [31:0] s_re, s_im;
    logic [5:0] s_idx;
    exp_t e;
    q.delete();
    @(posedge clk); #1;
    randomize_inputs(0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (got < 64 && cyc < 2000) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        errors++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, out_ready | ~out_valid);
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || P_re !== s_re || P_im !== s_im || out_idx !== s_idx) begin
          errors++; $display("FAIL stream_stall_hold: got v=%b %h/%h/%0d expected v=1 %h/%h/%0d",
                             out_valid, P_re, P_im, out_idx, s_re, s_im, s_idx);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_spurious: got out_idx=%0d expected no output", out_idx);
        end else if (P_re !== q[0].re || P_im !== q[0].im || out_idx !== q[0].idx) begin
          errors++; $display("FAIL stream_data: got %h/%h/%0d expected %h/%h/%0d",
                             P_re, P_im, out_idx, q[0].re, q[0].im, q[0].idx);
        end
        if (out_ready && q.size() != 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      acc_in = in_valid & in_ready;
      if (acc_in) begin
        e = model(A_re, A_im, B_re, B_im, in_idx, conj_b);
        q.push_back(e);
        sent++;
      end
      stall_prev = out_valid & ~out_ready;
      s_re = P_re; s_im = P_im; s_idx = out_idx;
      @(posedge clk); #1;
      if (acc_in) begin
        if (sent < 64) randomize_inputs(sent);
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < 60);
      cyc++;
    end
    checks++;
    if (got != 64 || sent != 64) begin
      errors++; $display("FAIL stream_count: got %0d out/%0d in expected 64/64 within budget", got, sent);
    end
    in_valid = 1'b0; out_ready = 1'b1; conj_b = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_duplicate: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_bubbles();
    logic exp_pat [6];
    exp_t e [2];
    int n = 0;
    exp_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 0 || k == 2);
      randomize_inputs(k + 10);
      if (in_valid) begin
        e[n] = model(A_re, A_im, B_re, B_im, in_idx, conj_b);
        n++;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== exp_pat[k]) begin
        errors++; $display("FAIL bubble_valid_%0d: got %b expected %b", k, out_valid, exp_pat[k]);
      end
      if (k == 2 || k == 4) begin
        checks++;
        if (P_re !== e[k/2-1].re || P_im !== e[k/2-1].im || out_idx !== e[k/2-1].idx) begin
          errors++; $display("FAIL bubble_data_%0d: got %h/%h/%0d expected %h/%h/%0d", k,
                             P_re, P_im, out_idx, e[k/2-1].re, e[k/2-1].im, e[k/2-1].idx);
        end
      end
    end
    in_valid = 1'b0; conj_b = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      randomize_inputs(k + 20);
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: out_valid got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (P_re !== 32'h0 || P_im !== 32'h0) begin errors++; $display("FAIL midrst_P: got %h/%h expected 0/0", P_re, P_im); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0; conj_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop_%0d: out_valid got %b expected 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_vector("basic", 16'sh1000, 16'sh0000, 16'sh4000, 16'sh0000, 6'd5, 1'b0, 32'h0400_0000, 32'h0000_0000);
    test_vector("signs", 16'sd1, 16'sd2, 16'sd3, 16'sd4, 6'd9, 1'b0, 32'hFFFF_FFFB, 32'h0000_000A);
    test_vector("wrap", -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 6'd63, 1'b0, 32'h0000_0000, 32'h8000_0000);
`ifdef CMULT_CONJ_EN
    test_vector("conj", 16'sd1, 16'sd2, 16'sd3, 16'sd4, 6'd12, 1'b1, 32'd11, 32'd2);
`endif
    test_back_to_back();
    test_bubbles();
    test_reset_midstream();
    test_vector("post_reset", 16'sh1000, 16'sh0000, 16'sh4000, 16'sh0000, 6'd5, 1'b0, 32'h0400_0000, 32'h0000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
